// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage core: load-use bubbles,
// multi-cycle flush after taken branches/jumps, and a global freeze while
// instruction or data memory is busy. Saturating event counters for debug.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal issue; accepts taken branches and load-use hazards
// ST_FLUSH | remaining flush cycles of a taken branch (flush_left > 0)

module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_wr_addr,
    input  logic             ex_mem_r,
    input  logic             ex_branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             ID_EX_stall,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // The first flush cycle is spent in ST_RUN, so the counter covers the rest.
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    logic busy;
    logic rs1_hit;
    logic rs2_hit;
    logic lu;
    logic acc_flush;
    logic acc_lu;

    assign busy    = imem_busy | dmem_busy;
    assign rs1_hit = id_rs1_used & (id_rs1_addr == ex_wr_addr);
    assign rs2_hit = id_rs2_used & (id_rs2_addr == ex_wr_addr);
    // x0 is never written, so a load targeting it cannot create a hazard.
    assign lu      = ex_mem_r & (ex_wr_addr != 5'd0) & (rs1_hit | rs2_hit);

    // Stall/flush decode and next-state; busy freezes everything including the FSM.
    always_comb begin
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        acc_flush    = 1'b0;
        acc_lu       = 1'b0;
        state_d      = state_q;
        flush_left_d = flush_left_q;

        if (busy) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_stall = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // A taken branch squashes the dependent instruction anyway.
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                        acc_flush   = 1'b1;
                        if (FLUSH_LEN > 1) begin
                            state_d      = ST_FLUSH;
                            flush_left_d = FLUSH_INIT;
                        end
                    end else if (lu) begin
                        pc_stall    = 1'b1;
                        IF_ID_stall = 1'b1;
                        ID_EX_flush = 1'b1;
                        acc_lu      = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    IF_ID_flush  = 1'b1;
                    ID_EX_flush  = 1'b1;
                    flush_left_d = flush_left_q - 3'd1;
                    if (flush_left_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d      = ST_RUN;
                    flush_left_d = 3'd0;
                end
            endcase
        end
    end

    // Saturating event counters; clear wins over any increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            lu_cnt_d    = '0;
        end else begin
            if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (acc_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
            if (acc_lu && (lu_cnt_q != CNT_MAX)) begin
                lu_cnt_d = lu_cnt_q + CNT_ONE;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            flush_left_q <= 3'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            lu_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            lu_cnt_q     <= lu_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign lu_cnt    = lu_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (FLUSH_LEN=2, CNT_W=4). Expected output
// vectors are queued as each cycle's stimulus is applied and popped when the
// combinational outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    // Output vector: {pc, IF_ID_st, ID_EX_st, EX_MEM_st, MEM_WB_st, IF_ID_fl, ID_EX_fl}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_BUSY = 7'b1111100;
    localparam logic [6:0] O_LU   = 7'b1100001;
    localparam logic [6:0] O_FL   = 7'b0000011;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_wr_addr;
    logic             id_rs1_used, id_rs2_used, ex_mem_r, ex_branch_taken;
    logic             imem_busy, dmem_busy, cnt_clr;
    logic             pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
    logic             IF_ID_flush, ID_EX_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, lu_cnt;
    logic [6:0]       outs;

    logic [6:0]       exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    assign outs = {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
                   IF_ID_flush, ID_EX_flush};

    pipeline_hazard_ctrl #(.FLUSH_LEN(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_wr_addr(ex_wr_addr), .ex_mem_r(ex_mem_r),
        .ex_branch_taken(ex_branch_taken),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
        .EX_MEM_stall(EX_MEM_stall), .MEM_WB_stall(MEM_WB_stall),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // v = {branch, dmem_busy, imem_busy, load-use on rs2 with x5}
    task automatic apply(input logic [3:0] v);
        ex_branch_taken = v[3];
        dmem_busy       = v[2];
        imem_busy       = v[1];
        ex_mem_r        = v[0];
        ex_wr_addr      = v[0] ? 5'd5 : 5'd0;
        id_rs2_used     = v[0];
        id_rs2_addr     = v[0] ? 5'd5 : 5'd0;
        id_rs1_used     = 1'b0;
        id_rs1_addr     = 5'd0;
        cnt_clr         = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        apply(4'b0000);
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        rst = 1'b0;
        apply(4'b0000);
        #2;
        n_checks++;
        if (outs !== O_IDLE) $display("FAIL reset_outs: got %b required %b", outs, O_IDLE);
        else n_pass++;
        n_checks++;
        if ({stall_cnt, flush_cnt, lu_cnt} !== '0)
            $display("FAIL reset_cnts: got %h/%h/%h required 0/0/0", stall_cnt, flush_cnt, lu_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(O_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL idle_after_reset[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        typedef struct packed {
            logic       mem_r;
            logic [4:0] wr;
            logic       rs1u;
            logic [4:0] rs1;
            logic       rs2u;
            logic [4:0] rs2;
            logic [6:0] e;
        } lu_vec_t;
        lu_vec_t vecs [7];
        lu_vec_t v;
        logic [6:0] e;
        vecs[0] = '{1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, O_LU};
        vecs[1] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, O_IDLE};
        vecs[2] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, O_IDLE};
        vecs[3] = '{1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, O_LU};
        vecs[4] = '{1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, O_IDLE};
        vecs[5] = '{1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, O_IDLE};
        vecs[6] = '{1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd4, O_IDLE};
        clear_counters();
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            apply(4'b0000);
            ex_mem_r    = v.mem_r;
            ex_wr_addr  = v.wr;
            id_rs1_used = v.rs1u;
            id_rs1_addr = v.rs1;
            id_rs2_used = v.rs2u;
            id_rs2_addr = v.rs2;
            exp_q.push_back(v.e);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL load_use[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
            if (i == 0) begin
                n_checks++;
                if ({lu_cnt, stall_cnt} !== {4'd1, 4'd1})
                    $display("FAIL load_use_first_cnts: got lu=%0d stall=%0d required lu=1 stall=1", lu_cnt, stall_cnt);
                else n_pass++;
            end
        end
        apply(4'b0000);
        n_checks++;
        if ({lu_cnt, stall_cnt, flush_cnt} !== {4'd2, 4'd2, 4'd0})
            $display("FAIL load_use_cnts: got lu=%0d stall=%0d flush=%0d required 2/2/0", lu_cnt, stall_cnt, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_branch();
        logic [3:0] s [4];
        logic [6:0] x [4];
        logic [6:0] e;
        s = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
        x = '{O_FL,    O_FL,    O_IDLE,  O_IDLE};
        clear_counters();
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL branch[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0})
            $display("FAIL branch_cnts: got flush=%0d stall=%0d required 1/0", flush_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_branch_busy();
        logic [3:0] s [6];
        logic [6:0] x [6];
        logic [6:0] e;
        s = '{4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
        x = '{O_BUSY,  O_BUSY,  O_BUSY,  O_FL,    O_FL,    O_IDLE};
        clear_counters();
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL branch_busy[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd3})
            $display("FAIL branch_busy_cnts: got flush=%0d stall=%0d required 1/3", flush_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_flush_extend();
        logic [3:0] s [5];
        logic [6:0] x [5];
        logic [6:0] e;
        s = '{4'b1000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        x = '{O_FL,    O_BUSY,  O_BUSY,  O_FL,    O_IDLE};
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL flush_extend[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd2})
            $display("FAIL flush_extend_cnts: got flush=%0d stall=%0d required 1/2", flush_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_branch_lu();
        logic [3:0] s [5];
        logic [6:0] x [5];
        logic [6:0] e;
        s = '{4'b1001, 4'b0001, 4'b0101, 4'b0001, 4'b0000};
        x = '{O_FL,    O_FL,    O_BUSY,  O_LU,    O_IDLE};
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL branch_lu[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
            if (i == 1) begin
                n_checks++;
                if (lu_cnt !== 4'd0) $display("FAIL branch_lu_no_lu: got lu=%0d required 0", lu_cnt);
                else n_pass++;
            end
        end
        n_checks++;
        if ({flush_cnt, lu_cnt, stall_cnt} !== {4'd1, 4'd1, 4'd2})
            $display("FAIL branch_lu_cnts: got flush=%0d lu=%0d stall=%0d required 1/1/2", flush_cnt, lu_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] s [5];
        logic [6:0] x [5];
        logic [6:0] e;
        s = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        x = '{O_FL,    O_FL,    O_FL,    O_FL,    O_IDLE};
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL back_to_back[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if (flush_cnt !== 4'd2) $display("FAIL back_to_back_cnt: got flush=%0d required 2", flush_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation_clear();
        logic [6:0] e;
        clear_counters();
        for (int i = 0; i < 20; i++) begin
            apply(4'b0100);
            exp_q.push_back(O_BUSY);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (outs !== e) $display("FAIL sat_busy[%0d]: got %b required %b", i, outs, e);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if (stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt: got %0d required 15", stall_cnt);
        else n_pass++;
        // Clear while still busy: clear must win over the increment.
        apply(4'b0100);
        cnt_clr = 1'b1;
        next_cycle();
        apply(4'b0000);
        n_checks++;
        if (stall_cnt !== 4'd0) $display("FAIL clr_stall_cnt: got %0d required 0", stall_cnt);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (stall_cnt !== 4'd0) $display("FAIL clr_hold: got %0d required 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        logic [6:0] e;
        apply(4'b1000);
        next_cycle();
        apply(4'b0000);
        @(negedge clk);
        n_checks++;
        if (outs !== O_FL) $display("FAIL pre_reset_flush: got %b required %b", outs, O_FL);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_IDLE) $display("FAIL reset_mid_flush_outs: got %b required %b", outs, O_IDLE);
        else n_pass++;
        n_checks++;
        if (flush_cnt !== 4'd0) $display("FAIL reset_mid_flush_cnt: got %0d required 0", flush_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        exp_q.push_back(O_IDLE);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (outs !== e) $display("FAIL after_reset_run: got %b required %b", outs, e);
        else n_pass++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_branch_busy();
        test_flush_extend();
        test_branch_lu();
        test_back_to_back();
        test_saturation_clear();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
